forward_ctrl: RTL and testbench
===============================

# forward_ctrl

Hazard and forwarding controller for the 5-stage 64-bit pipeline, producing the 2-bit select codes consumed by the EX-stage 3:1 operand multiplexers. It tracks destination registers through its own ID/EX, EX/MEM and MEM/WB shadow registers, and drives registered forwarding selects that are valid for the whole cycle an instruction sits in EX. It also detects load-use hazards, requests a one-cycle stall and inserts a bubble. Flush and memory-busy freeze inputs come from the branch unit and the data-memory port.

## Interface
- REG_ADDR_W, 5, register-index width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction present in ID
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read (immediate/LUI forms set these to 0)
- id_rd  in  REG_ADDR_W  ID destination
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch/jump redirect: kill the ID instruction
- mem_busy  in  1  data memory not ready: freeze the whole pipeline
- forward_a, forward_b  out  2  EX operand selects: 00 register file, 01 writeback result, 10 EX/MEM ALU result; 11 never driven
- stall  out  1  hold PC and IF/ID; combinational from current state and ID inputs
- freeze  out  1  equals mem_busy; all pipeline registers hold

## Operation
- Shadow stages are ide, exm and mwb. Each holds {valid, rd, reg_write, mem_read}.
- Normal advance (no freeze, no stall):
  - ide <= ID fields, with valid = id_valid & ~flush.
  - exm <= ide.
  - mwb <= exm.
- Load-use hazard, when all of these hold:
  - ide.valid, ide.mem_read and ide.rd != 0;
  - ide.rd == id_rs1 with id_rs1_used, or ide.rd == id_rs2 with id_rs2_used.
- On a load-use hazard:
  - stall = 1;
  - ide <= bubble (valid = 0);
  - exm and mwb advance;
  - forward_a and forward_b <= 00.
- Forward select computation, done on the advance edge for operand X in {rs1, rs2}:
  - 10 if ide.valid, ide.reg_write, ide.rd != 0 and ide.rd == id_rsX. That instruction will be in EX/MEM when ours is in EX.
  - Else 01 if exm.valid, exm.reg_write, exm.rd != 0 and exm.rd == id_rsX. That instruction will be in MEM/WB.
  - Else 00. The register file is write-through, so an instruction in mwb needs no forwarding.
  - Newer producer (10) has priority over older (01).
  - rsX_used = 0 forces 00.
  - rd == 0 never forwards.
- flush with stall in the same cycle: flush wins. The ID instruction is killed, stall = 0, ide <= bubble and selects <= 00.
- freeze (mem_busy = 1): all shadows and both selects hold their values. stall is forced to 0 and flush is ignored. The branch unit must hold flush until freeze drops.
- id_valid = 0: treated as a bubble. No hazard, selects <= 00.

## Timing
- Reset (rst_n low, asynchronous): all shadow valid = 0, forward_a = forward_b = 00, stall = 0. Release is synchronous to the next clk edge.
- Select latency: 1 cycle. Values are computed in ID and registered at the ID→EX edge, so they are stable through the entire EX cycle.
- stall has 0-cycle latency (combinational) and lasts exactly one cycle per load-use hazard.
  - On the next cycle the load is in exm. The dependent instruction then gets 01 on entry to EX.
- Back-to-back loads that both feed a consumer: at most one stall cycle, since the older load is already in exm.
- Reset asserted mid-stall or mid-freeze: state clears immediately and no residual stall remains.

## Structure
- Shared package pipe_pkg:
  - fwd_sel_t enum: FWD_REGFILE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - stage_tag_t packed struct: valid, rd, reg_write, mem_read.
  - REG_ADDR_W constant.
- Sub-module fwd_match, instantiated once per source operand:
  - inputs: rs, rs_used, ide tag, exm tag;
  - output: a fwd_sel_t plus a load-use hit bit.
- Top level holds the shadow flops, the stall/flush/freeze priority (reset > freeze > flush > stall > advance), and the select registers.

## Test plan
- Forward from EX/MEM: add x5 then sub x6, x5, x7 back-to-back -> forward_a = 10 during the sub's EX cycle, forward_b = 00, stall never 1.
- Forward from MEM/WB with priority: add x5; add x5; nop; use x5 -> 01 from one gap. With two consecutive writers of x5 followed immediately by the consumer -> 10 (newest wins).
- Load-use: ld x8 then add x9, x8, x8 -> stall = 1 for exactly one cycle, bubble in ide, then forward_a = forward_b = 01 in the add's EX cycle.
- x0 and unused sources: add x0 then add x1, x0, x0 -> selects 00. A writer of x3 followed by lui x3 (rs1_used = 0) -> 00.
- Flush during a load-use hazard: flush = 1 in the stall cycle -> stall = 0 and ide invalid; the following instruction sees selects 00.
- Freeze and reset: mem_busy held 3 cycles mid-forward -> forward_a held at 10 and shadows unchanged. Then pull rst_n low asynchronously mid-freeze -> selects 00, stall 0 before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the 5-stage pipeline hazard/forwarding logic.
//   fwd_sel_t   - EX operand mux select (regfile / writeback / EX-MEM ALU)
//   stage_tag_t - per-stage shadow of an instruction's destination info
//   REG_ADDR_W  - register index width
package pipe_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_REGFILE = 2'b00,
      FWD_WB      = 2'b01,
      FWD_MEM     = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } stage_tag_t;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: forwarding select and load-use detection for one source operand.
//   rs, rs_used - source register index in ID and whether it is really read
//   ide, exm    - shadow tags of the instructions one and two stages ahead
//   sel         - forwarding select this operand needs on entry to EX
//   load_hit    - the instruction directly ahead is a load producing rs
module fwd_match
   import pipe_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  rs_used,
   input  stage_tag_t            ide,
   input  stage_tag_t            exm,
   output fwd_sel_t              sel,
   output logic                  load_hit
);

   logic ide_match;
   logic exm_match;

   // x0 is hard-wired zero, so a producer targeting it never matches.
   assign ide_match = rs_used && ide.valid && (ide.rd != '0) && (ide.rd == rs);
   assign exm_match = rs_used && exm.valid && (exm.rd != '0) && (exm.rd == rs);

   always_comb begin
      sel = FWD_REGFILE;
      // Newer producer wins over older one.
      if (ide_match && ide.reg_write) begin
         sel = FWD_MEM;
      end else if (exm_match && exm.reg_write) begin
         sel = FWD_WB;
      end
   end

   assign load_hit = ide_match && ide.mem_read;

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: hazard and forwarding controller for the 5-stage pipeline.
//   clk, rst_n            - clock, asynchronous active-low reset
//   id_*                  - decoded fields of the instruction currently in ID
//   flush                 - kill the ID instruction (branch redirect)
//   mem_busy              - data memory not ready, freeze everything
//   forward_a, forward_b  - registered EX operand selects
//   stall                 - hold PC and IF/ID (combinational)
//   freeze                - all pipeline registers hold (mirror of mem_busy)
module forward_ctrl
   import pipe_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   input  logic                  mem_busy,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  stall,
   output logic                  freeze
);

   stage_tag_t ide_reg;
   stage_tag_t exm_reg;
   stage_tag_t mwb_reg;
   stage_tag_t id_tag;
   fwd_sel_t   fwd_a_reg;
   fwd_sel_t   fwd_b_reg;

   logic [REG_ADDR_W-1:0] rs_arr   [2];
   logic                  used_arr [2];
   fwd_sel_t              sel_arr  [2];
   logic                  hit_arr  [2];
   logic                  hazard;

   assign rs_arr[0]   = id_rs1;
   assign rs_arr[1]   = id_rs2;
   assign used_arr[0] = id_rs1_used;
   assign used_arr[1] = id_rs2_used;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_match
         fwd_match u_match (
            .rs       (rs_arr[gi]),
            .rs_used  (used_arr[gi]),
            .ide      (ide_reg),
            .exm      (exm_reg),
            .sel      (sel_arr[gi]),
            .load_hit (hit_arr[gi])
         );
      end
   endgenerate

   assign id_tag = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

   // A bubble in ID can never be the consumer of a load.
   assign hazard = id_valid && (hit_arr[0] || hit_arr[1]);
   // Freeze and flush both mask the stall request.
   assign stall  = hazard && !flush && !mem_busy;
   assign freeze = mem_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ide_reg   <= '0;
         exm_reg   <= '0;
         mwb_reg   <= '0;
         fwd_a_reg <= FWD_REGFILE;
         fwd_b_reg <= FWD_REGFILE;
      end else if (mem_busy) begin
         // Everything holds; flush is expected to be re-presented afterwards.
         ide_reg   <= ide_reg;
      end else if (flush || hazard) begin
         // Killed or stalled ID instruction: a bubble enters EX, older ones drain.
         ide_reg   <= '0;
         exm_reg   <= ide_reg;
         mwb_reg   <= exm_reg;
         fwd_a_reg <= FWD_REGFILE;
         fwd_b_reg <= FWD_REGFILE;
      end else begin
         ide_reg   <= id_tag;
         exm_reg   <= ide_reg;
         mwb_reg   <= exm_reg;
         fwd_a_reg <= id_valid ? sel_arr[0] : FWD_REGFILE;
         fwd_b_reg <= id_valid ? sel_arr[1] : FWD_REGFILE;
      end
   end

   assign forward_a = fwd_a_reg;
   assign forward_b = fwd_b_reg;

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed tests for forward_ctrl with hand-computed selects.
module tb_forward_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       flush;
   logic       mem_busy;
   logic [1:0] forward_a;
   logic [1:0] forward_b;
   logic       stall;
   logic       freeze;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   forward_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .mem_busy     (mem_busy),
      .forward_a    (forward_a),
      .forward_b    (forward_b),
      .stall        (stall),
      .freeze       (freeze)
   );

   always #5 clk = ~clk;

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs1_used  = u1;
      id_rs2       = rs2;
      id_rs2_used  = u2;
      id_rd        = rd;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   // One clock; afterwards outputs are sampled 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      $display("cycle %0d: id_v=%b rs1=%0d rs2=%0d rd=%0d flush=%b busy=%b -> fa=%b fb=%b stall=%b",
               cyc, id_valid, id_rs1, id_rs2, id_rd, flush, mem_busy, forward_a, forward_b, stall);
   endtask

   task automatic nops(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; mem_busy = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL reset_fa: got %b expected 00", forward_a); end
      checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL reset_fb: got %b expected 00", forward_b); end
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (freeze !== 1'b0) begin fails++; $display("FAIL reset_freeze: got %b expected 0", freeze); end
      @(negedge clk);
      rst_n = 1'b1;
      nops(2);
   endtask

   task automatic test_fwd_exmem();
      nops(3);
      set_id(1, 1, 1, 2, 1, 5, 1, 0);            // add x5, x1, x2
      tick();
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL exmem_first_fa: got %b expected 00", forward_a); end
      set_id(1, 5, 1, 7, 1, 6, 1, 0);            // sub x6, x5, x7
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL exmem_stall: got %b expected 0", stall); end
      tick();
      checks++; if (forward_a !== 2'b10) begin fails++; $display("FAIL exmem_fa: got %b expected 10", forward_a); end
      checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL exmem_fb: got %b expected 00", forward_b); end
      nops(1);
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL exmem_nop_fa: got %b expected 00", forward_a); end
   endtask

   task automatic test_fwd_memwb();
      nops(3);
      set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();    // add x5
      set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();    // add x5
      set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();    // nop
      set_id(1, 5, 1, 3, 1, 9, 1, 0); tick();    // add x9, x5, x3
      checks++; if (forward_a !== 2'b01) begin fails++; $display("FAIL memwb_fa: got %b expected 01", forward_a); end
      checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL memwb_fb: got %b expected 00", forward_b); end
      nops(3);
      set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();    // add x5
      set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();    // add x5
      set_id(1, 5, 1, 5, 1, 9, 1, 0); tick();    // add x9, x5, x5
      checks++; if (forward_a !== 2'b10) begin fails++; $display("FAIL prio_fa: got %b expected 10", forward_a); end
      checks++; if (forward_b !== 2'b10) begin fails++; $display("FAIL prio_fb: got %b expected 10", forward_b); end
      nops(3);
   endtask

   task automatic test_load_use();
      int stall_cycles;
      nops(3);
      set_id(1, 2, 1, 0, 0, 8, 1, 1); tick();    // ld x8
      set_id(1, 8, 1, 8, 1, 9, 1, 0);            // add x9, x8, x8
      #1;
      checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b expected 1", stall); end
      tick();
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL lu_bubble_fa: got %b expected 00", forward_a); end
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_once: got %b expected 0", stall); end
      tick();
      checks++; if (forward_a !== 2'b01) begin fails++; $display("FAIL lu_fa: got %b expected 01", forward_a); end
      checks++; if (forward_b !== 2'b01) begin fails++; $display("FAIL lu_fb: got %b expected 01", forward_b); end
      // Two loads feeding one consumer: a single stall, older load via regfile.
      nops(3);
      set_id(1, 2, 1, 0, 0, 8, 1, 1); tick();    // ld x8
      set_id(1, 2, 1, 0, 0, 9, 1, 1); tick();    // ld x9
      set_id(1, 8, 1, 9, 1, 10, 1, 0);           // add x10, x8, x9
      stall_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (stall === 1'b1) stall_cycles++;
         if (stall !== 1'b1) break;
         tick();
      end
      checks++; if (stall_cycles != 1) begin fails++; $display("FAIL b2b_stall_cycles: got %0d expected 1", stall_cycles); end
      tick();
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL b2b_fa: got %b expected 00", forward_a); end
      checks++; if (forward_b !== 2'b01) begin fails++; $display("FAIL b2b_fb: got %b expected 01", forward_b); end
      nops(3);
   endtask

   task automatic test_x0_unused();
      nops(3);
      set_id(1, 1, 1, 2, 1, 0, 1, 0); tick();    // add x0
      set_id(1, 0, 1, 0, 1, 1, 1, 0); tick();    // add x1, x0, x0
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL x0_fa: got %b expected 00", forward_a); end
      checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL x0_fb: got %b expected 00", forward_b); end
      nops(3);
      set_id(1, 1, 1, 2, 1, 3, 1, 0); tick();    // add x3
      set_id(1, 3, 0, 3, 0, 4, 1, 0); tick();    // lui x4 (sources unused)
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL unused_fa: got %b expected 00", forward_a); end
      checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL unused_fb: got %b expected 00", forward_b); end
      nops(3);
      set_id(1, 2, 1, 0, 0, 0, 1, 1); tick();    // ld x0
      set_id(1, 0, 1, 0, 1, 6, 1, 0);            // add x6, x0, x0
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_load_stall: got %b expected 0", stall); end
      nops(3);
   endtask

   task automatic test_flush();
      nops(3);
      set_id(1, 2, 1, 0, 0, 8, 1, 1); tick();    // ld x8
      set_id(1, 8, 1, 8, 1, 9, 1, 0);            // add x9, x8, x8 with flush
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b expected 0", stall); end
      tick();
      flush = 1'b0;
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL flush_fa: got %b expected 00", forward_a); end
      // Reads the killed add's rd: a valid ide would give 10.
      set_id(1, 9, 1, 9, 1, 12, 1, 0);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_next_stall: got %b expected 0", stall); end
      tick();
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL flush_next_fa: got %b expected 00", forward_a); end
      checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL flush_next_fb: got %b expected 00", forward_b); end
      nops(3);
   endtask

   task automatic test_freeze_reset();
      nops(3);
      set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();    // add x5
      set_id(1, 5, 1, 7, 1, 6, 1, 0); tick();    // sub x6, x5, x7
      checks++; if (forward_a !== 2'b10) begin fails++; $display("FAIL frz_pre_fa: got %b expected 10", forward_a); end
      set_id(1, 6, 1, 5, 1, 11, 1, 0);           // consumer of x6 and x5
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (freeze !== 1'b1) begin fails++; $display("FAIL frz_freeze: got %b expected 1", freeze); end
         tick();
         checks++; if (forward_a !== 2'b10) begin fails++; $display("FAIL frz_hold_fa: got %b expected 10", forward_a); end
      end
      mem_busy = 1'b0;
      tick();
      checks++; if (forward_a !== 2'b10) begin fails++; $display("FAIL frz_after_fa: got %b expected 10", forward_a); end
      checks++; if (forward_b !== 2'b01) begin fails++; $display("FAIL frz_after_fb: got %b expected 01", forward_b); end
      // Stall masked during freeze, then reset mid-stall clears it at once.
      nops(3);
      set_id(1, 2, 1, 0, 0, 8, 1, 1); tick();    // ld x8
      set_id(1, 8, 1, 0, 0, 9, 1, 0);
      mem_busy = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL frz_stall_mask: got %b expected 0", stall); end
      mem_busy = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_pre_stall: got %b expected 1", stall); end
      rst_n = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b expected 0", stall); end
      @(negedge clk);
      rst_n = 1'b1;
      // Reset during freeze with a forwarded select live.
      nops(3);
      set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
      set_id(1, 5, 1, 5, 1, 6, 1, 0); tick();
      mem_busy = 1'b1;
      tick();
      checks++; if (forward_b !== 2'b10) begin fails++; $display("FAIL rstfrz_pre_fb: got %b expected 10", forward_b); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL rstfrz_fa: got %b expected 00", forward_a); end
      checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL rstfrz_fb: got %b expected 00", forward_b); end
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL rstfrz_stall: got %b expected 0", stall); end
      mem_busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nops(2);
   endtask

   initial begin
      test_reset();
      test_fwd_exmem();
      test_fwd_memwb();
      test_load_use();
      test_x0_unused();
      test_flush();
      test_freeze_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
